complex_div: RTL and testbench

- Iterative Q1.15 complex divider computing O = A / B.
- It is the inverse operation of the FFT datapath complex multiplier and is used for channel equalisation and normalisation after the FFT.
- Valid/ready handshakes on both sides; one division in flight at a time.
- Real and imaginary quotients are produced in parallel by shared-schedule restoring long division.

---
 rtl/complex_div.sv | 223 ++++++++++++++++++++++
 tb/tb_complex_div.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_div.sv
// Iterative Q1.15 complex divider O = A / B: conjugate multiply, then restoring
// long division of both numerator components against |B|^2 on a shared schedule.
module complex_div #(
   parameter int FRAC = 15,
   parameter int W    = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A_Real,
   input  logic [W-1:0] A_Im,
   input  logic [W-1:0] B_Real,
   input  logic [W-1:0] B_Im,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] O_Real,
   output logic [W-1:0] O_Im,
   output logic         div_zero,
   output logic         sat
);
   localparam int PW = 2 * W;
   localparam int CW = $clog2(FRAC + 1);
   localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MUL, CHK, DIV, DONE} state_t;

   state_t                state_q, state_d;
   logic signed [W-1:0]   ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
   logic signed [PW:0]    nr_q, nr_d, ni_q, ni_d;
   logic [PW-1:0]         den_q, den_d;
   logic [PW-1:0]         rem_r_q, rem_r_d, rem_i_q, rem_i_d;
   logic [FRAC-1:0]       q_r_q, q_r_d, q_i_q, q_i_d;
   logic                  neg_r_q, neg_r_d, neg_i_q, neg_i_d;
   logic                  sat_r_q, sat_r_d, sat_i_q, sat_i_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [W-1:0]          o_real_q, o_real_d, o_im_q, o_im_d;
   logic                  out_valid_q, out_valid_d, in_ready_q, in_ready_d;
   logic                  div_zero_q, div_zero_d, sat_q, sat_d;

   logic signed [PW-1:0]  p_ar_br, p_ai_bi, p_ai_br, p_ar_bi, p_br_br, p_bi_bi;
   logic [PW:0]           mag_r, mag_i, den_x, sh_r, sh_i;

   // Full-precision products; |B|^2 reaches 2^31 and stays unsigned.
   assign p_ar_br = PW'(ar_q) * PW'(br_q);
   assign p_ai_bi = PW'(ai_q) * PW'(bi_q);
   assign p_ai_br = PW'(ai_q) * PW'(br_q);
   assign p_ar_bi = PW'(ar_q) * PW'(bi_q);
   assign p_br_br = PW'(br_q) * PW'(br_q);
   assign p_bi_bi = PW'(bi_q) * PW'(bi_q);

   assign mag_r = nr_q[PW] ? $unsigned(-nr_q) : $unsigned(nr_q);
   assign mag_i = ni_q[PW] ? $unsigned(-ni_q) : $unsigned(ni_q);
   assign den_x = {1'b0, den_q};
   assign sh_r  = {rem_r_q, 1'b0};
   assign sh_i  = {rem_i_q, 1'b0};

   function automatic logic [W-1:0] fmt(input logic neg, input logic s, input logic [FRAC-1:0] q);
      logic [W-1:0] m;
      m = W'(q);
      if (s) return neg ? SAT_NEG : SAT_POS;
      return neg ? -m : m;
   endfunction

   always_comb begin
      state_d     = state_q;
      ar_d        = ar_q;
      ai_d        = ai_q;
      br_d        = br_q;
      bi_d        = bi_q;
      nr_d        = nr_q;
      ni_d        = ni_q;
      den_d       = den_q;
      rem_r_d     = rem_r_q;
      rem_i_d     = rem_i_q;
      q_r_d       = q_r_q;
      q_i_d       = q_i_q;
      neg_r_d     = neg_r_q;
      neg_i_d     = neg_i_q;
      sat_r_d     = sat_r_q;
      sat_i_d     = sat_i_q;
      cnt_d       = cnt_q;
      o_real_d    = o_real_q;
      o_im_d      = o_im_q;
      out_valid_d = out_valid_q;
      div_zero_d  = div_zero_q;
      sat_d       = sat_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               ar_d    = A_Real;
               ai_d    = A_Im;
               br_d    = B_Real;
               bi_d    = B_Im;
               state_d = MUL;
            end
         end
         MUL: begin
            nr_d    = (PW+1)'(p_ar_br) + (PW+1)'(p_ai_bi);
            ni_d    = (PW+1)'(p_ai_br) - (PW+1)'(p_ar_bi);
            den_d   = $unsigned(p_br_br) + $unsigned(p_bi_bi);
            state_d = CHK;
         end
         CHK: begin
            neg_r_d = nr_q[PW];
            neg_i_d = ni_q[PW];
            sat_r_d = (mag_r >= den_x);
            sat_i_d = (mag_i >= den_x);
            rem_r_d = PW'(mag_r);
            rem_i_d = PW'(mag_i);
            q_r_d   = '0;
            q_i_d   = '0;
            cnt_d   = '0;
            state_d = (den_q == '0) ? DONE : DIV;
         end
         DIV: begin
            // Remainder stays below den, so the doubled value fits in PW+1 bits.
            if (!sat_r_q) begin
               if (sh_r >= den_x) begin
                  rem_r_d = PW'(sh_r - den_x);
                  q_r_d   = {q_r_q[FRAC-2:0], 1'b1};
               end else begin
                  rem_r_d = PW'(sh_r);
                  q_r_d   = {q_r_q[FRAC-2:0], 1'b0};
               end
            end
            if (!sat_i_q) begin
               if (sh_i >= den_x) begin
                  rem_i_d = PW'(sh_i - den_x);
                  q_i_d   = {q_i_q[FRAC-2:0], 1'b1};
               end else begin
                  rem_i_d = PW'(sh_i);
                  q_i_d   = {q_i_q[FRAC-2:0], 1'b0};
               end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(FRAC - 1)) state_d = DONE;
         end
         DONE: begin
            // First DONE cycle loads the result registers; they then hold until consumed.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               if (den_q == '0) begin
                  o_real_d   = '0;
                  o_im_d     = '0;
                  div_zero_d = 1'b1;
                  sat_d      = 1'b0;
               end else begin
                  o_real_d   = fmt(neg_r_q, sat_r_q, q_r_q);
                  o_im_d     = fmt(neg_i_q, sat_i_q, q_i_q);
                  div_zero_d = 1'b0;
                  sat_d      = sat_r_q | sat_i_q;
               end
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ar_q        <= '0;
         ai_q        <= '0;
         br_q        <= '0;
         bi_q        <= '0;
         nr_q        <= '0;
         ni_q        <= '0;
         den_q       <= '0;
         rem_r_q     <= '0;
         rem_i_q     <= '0;
         q_r_q       <= '0;
         q_i_q       <= '0;
         neg_r_q     <= 1'b0;
         neg_i_q     <= 1'b0;
         sat_r_q     <= 1'b0;
         sat_i_q     <= 1'b0;
         cnt_q       <= '0;
         o_real_q    <= '0;
         o_im_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         div_zero_q  <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ar_q        <= ar_d;
         ai_q        <= ai_d;
         br_q        <= br_d;
         bi_q        <= bi_d;
         nr_q        <= nr_d;
         ni_q        <= ni_d;
         den_q       <= den_d;
         rem_r_q     <= rem_r_d;
         rem_i_q     <= rem_i_d;
         q_r_q       <= q_r_d;
         q_i_q       <= q_i_d;
         neg_r_q     <= neg_r_d;
         neg_i_q     <= neg_i_d;
         sat_r_q     <= sat_r_d;
         sat_i_q     <= sat_i_d;
         cnt_q       <= cnt_d;
         o_real_q    <= o_real_d;
         o_im_q      <= o_im_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         div_zero_q  <= div_zero_d;
         sat_q       <= sat_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign O_Real    = o_real_q;
   assign O_Im      = o_im_q;
   assign div_zero  = div_zero_q;
   assign sat       = sat_q;
endmodule

// File: tb/tb_complex_div.sv
// Bench for complex_div: directed cases with hand-derived results, handshake and
// reset checks, then a randomized back-to-back run against an arithmetic model.
module tb_complex_div;
   localparam int NVEC = 2500;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A_Real, A_Im, B_Real, B_Im;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] O_Real, O_Im;
   logic        div_zero;
   logic        sat;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   complex_div #(.FRAC(15), .W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A_Real    (A_Real),
      .A_Im      (A_Im),
      .B_Real    (B_Real),
      .B_Im      (B_Im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .O_Real    (O_Real),
      .O_Im      (O_Im),
      .div_zero  (div_zero),
      .sat       (sat)
   );

   // Quotient component n/den in Q1.15, truncated toward zero, clamped when |n| >= den.
   function automatic logic [15:0] ref_component(input longint n, input longint den, output logic s);
      longint mag, q;
      mag = (n < 0) ? -n : n;
      s   = (mag >= den);
      if (s) q = (n < 0) ? -32768 : 32767;
      else begin
         q = (mag * 32768) / den;
         if (n < 0) q = -q;
      end
      return q[15:0];
   endfunction

   task automatic ref_div(input logic [15:0] ar, ai, br, bi,
                          output logic [15:0] er, ei, output logic edz, esat);
      longint a_r, a_i, b_r, b_i, nr, ni, den;
      logic   s_r, s_i;
      a_r = longint'($signed(ar));
      a_i = longint'($signed(ai));
      b_r = longint'($signed(br));
      b_i = longint'($signed(bi));
      nr  = a_r * b_r + a_i * b_i;
      ni  = a_i * b_r - a_r * b_i;
      den = b_r * b_r + b_i * b_i;
      if (den == 0) begin
         er = '0; ei = '0; edz = 1'b1; esat = 1'b0;
      end else begin
         er   = ref_component(nr, den, s_r);
         ei   = ref_component(ni, den, s_i);
         edz  = 1'b0;
         esat = s_r | s_i;
      end
   endtask

   function automatic logic [15:0] rnd_operand(input bit numerator);
      logic [15:0] v;
      int          sel;
      sel = $urandom_range(0, 7);
      v   = 16'($urandom);
      if (sel == 0) v = 16'h8000;
      else if (sel == 1) v = 16'h0000;
      else if (numerator && sel < 5) v = 16'($signed(v) >>> $urandom_range(1, 10));
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected)
      else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; leaves the bench at the negedge where out_valid is seen (or the bound expired).
   task automatic applyStimulus(input logic [15:0] ar, ai, br, bi, input bit hold_valid, output int edges);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      A_Real   = ar;
      A_Im     = ai;
      B_Real   = br;
      B_Im     = bi;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = hold_valid;
      A_Real   = 16'($urandom);
      A_Im     = 16'($urandom);
      B_Real   = 16'($urandom);
      B_Im     = 16'($urandom);
      edges    = 0;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   task automatic checkResult(input string tag, input int edges, input logic [15:0] er, ei,
                              input logic edz, esat, input int elat);
      checkOutput({tag, "_latency"}, 32'(edges), 32'(elat));
      checkOutput({tag, "_o_real"}, 32'(O_Real), 32'(er));
      checkOutput({tag, "_o_im"}, 32'(O_Im), 32'(ei));
      checkOutput({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
      checkOutput({tag, "_sat"}, 32'(sat), 32'(esat));
   endtask

   task automatic consumeResult(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic runCase(input string tag, input logic [15:0] ar, ai, br, bi,
                          input logic [15:0] er, ei, input logic edz, esat, input int elat);
      int edges;
      applyStimulus(ar, ai, br, bi, 1'b0, edges);
      checkResult(tag, edges, er, ei, edz, esat, elat);
      consumeResult(tag);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          edges;
      logic [15:0] ar, ai, br, bi, er, ei;
      logic        edz, esat;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A_Real = '0; A_Im = '0; B_Real = '0; B_Im = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_outputs", {O_Real, O_Im}, 32'd0);
      checkOutput("rst_flags", {30'd0, div_zero, sat}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      runCase("basic",   16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 18);
      runCase("diag",    16'h2000, 16'h2000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b0, 18);
      runCase("imag",    16'h0000, 16'h2000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0, 18);
      runCase("neg",     16'hE000, 16'h0000, 16'h4000, 16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b0, 18);
      runCase("sat",     16'h4000, 16'hC000, 16'h2000, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 18);
      runCase("divzero", 16'h1234, 16'h0567, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 3);

      $display("[TB] backpressure");
      applyStimulus(16'h2000, 16'h0000, 16'h4000, 16'h0000, 1'b0, edges);
      checkResult("bp", edges, 16'h4000, 16'h0000, 1'b0, 1'b0, 18);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            in_valid = 1'b1;
            A_Real = 16'h7000; A_Im = 16'h1111; B_Real = 16'h1000; B_Im = 16'h0000;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("bp_hold_out_%0d", i), {O_Real, O_Im}, {16'h4000, 16'h0000});
         checkOutput($sformatf("bp_hold_ctl_%0d", i), {29'd0, out_valid, in_ready, sat}, {29'd0, 3'b100});
      end
      in_valid = 1'b0;
      consumeResult("bp");
      repeat (25) @(posedge clk);
      @(negedge clk);
      checkOutput("bp_no_ghost", 32'(out_valid), 32'd0);

      $display("[TB] reset during division");
      A_Real = 16'h2000; A_Im = 16'h0000; B_Real = 16'h4000; B_Im = 16'h0000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_outputs", {O_Real, O_Im}, 32'd0);
      checkOutput("midrst_flags", {30'd0, div_zero, sat}, 32'd0);
      repeat (25) @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_no_result", 32'(out_valid), 32'd0);
      runCase("after_rst", 16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 18);

      $display("[TB] random back-to-back regression");
      out_ready = 1'b1;
      for (int v = 0; v < NVEC; v++) begin
         ar = rnd_operand(1'b1);
         ai = rnd_operand(1'b1);
         br = rnd_operand(1'b0);
         bi = rnd_operand(1'b0);
         ref_div(ar, ai, br, bi, er, ei, edz, esat);
         applyStimulus(ar, ai, br, bi, 1'b1, edges);
         checkResult($sformatf("rnd%0d", v), edges, er, ei, edz, esat, edz ? 3 : 18);
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("rnd%0d_valid_clr", v), 32'(out_valid), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
